// File: rtl/contador_pkg.sv
// Shared types and defaults for the loadable down-counter.
package contador_pkg;

    localparam int WIDTH_DEF = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CONTANDO = 2'd1,
        FIN      = 2'd2
    } estado_t;

endpackage

// File: rtl/contador_abajo_carga.sv
// Loadable down-counter with one-shot / periodic reload and a registered
// terminal-count pulse. All state advances on the falling edge of clk.
//
// state    | meaning
// IDLE     | stopped, cuenta held, enable ignored
// CONTANDO | decrementing on each enabled edge
// FIN      | one cycle after terminal count or zero load, cero=1
module contador_abajo_carga
    import contador_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] valor_carga,
    input  logic             recarga_auto,
    output logic [WIDTH-1:0] cuenta,
    output logic             cero,
    output logic             ocupado
);

    localparam logic [WIDTH-1:0] UNO = WIDTH'(1);

    estado_t          estado_q,  estado_d;
    logic [WIDTH-1:0] cuenta_q,  cuenta_d;
    logic [WIDTH-1:0] recarga_q, recarga_d;
    logic             cero_q,    cero_d;

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            estado_q  <= IDLE;
            cuenta_q  <= '0;
            recarga_q <= '0;
            cero_q    <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            cuenta_q  <= cuenta_d;
            recarga_q <= recarga_d;
            cero_q    <= cero_d;
        end
    end

    always_comb begin
        estado_d  = estado_q;
        cuenta_d  = cuenta_q;
        recarga_d = recarga_q;
        cero_d    = 1'b0;
        if (load) begin
            // A load never decrements; a zero load goes straight to FIN.
            cuenta_d  = valor_carga;
            recarga_d = valor_carga;
            if (valor_carga != '0) begin
                estado_d = CONTANDO;
            end else begin
                estado_d = FIN;
                cero_d   = 1'b1;
            end
        end else begin
            case (estado_q)
                IDLE: begin
                    estado_d = IDLE;
                end
                CONTANDO: begin
                    if (enable) begin
                        if (cuenta_q == UNO) begin
                            cero_d = 1'b1;
                            if (recarga_auto) begin
                                cuenta_d = recarga_q;
                            end else begin
                                cuenta_d = '0;
                                estado_d = FIN;
                            end
                        end else begin
                            cuenta_d = cuenta_q - UNO;
                        end
                    end
                end
                FIN: begin
                    estado_d = IDLE;
                end
                default: begin
                    estado_d = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        cuenta  = cuenta_q;
        cero    = cero_q;
        ocupado = (estado_q == CONTANDO);
    end

endmodule

// File: tb/tb_contador_abajo_carga.sv
// Directed bench for contador_abajo_carga: checks count, cero and ocupado
// after each falling edge against hand-computed values.
module tb_contador_abajo_carga;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         enable;
    logic         load;
    logic [W-1:0] valor_carga;
    logic         recarga_auto;
    logic [W-1:0] cuenta;
    logic         cero;
    logic         ocupado;

    int errors = 0;
    int checks = 0;

    contador_abajo_carga #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .load         (load),
        .valor_carga  (valor_carga),
        .recarga_auto (recarga_auto),
        .cuenta       (cuenta),
        .cero         (cero),
        .ocupado      (ocupado)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int c, input bit z, input bit o);
        chk({tag, ".cuenta"},  16'(cuenta),  16'(c));
        chk({tag, ".cero"},    16'(cero),    16'(z));
        chk({tag, ".ocupado"}, 16'(ocupado), 16'(o));
    endtask

    initial begin
        int seq[10];
        seq = '{4, 3, 2, 1, 5, 4, 3, 2, 1, 5};

        rst = 1'b0; enable = 1'b0; load = 1'b0;
        valor_carga = '0; recarga_auto = 1'b0;
        #12;
        chk_all("reset", 0, 0, 0);
        rst = 1'b1;

        // idle after reset: enable has no effect, no wrap from 0
        enable = 1'b1;
        tick(); chk_all("idle0", 0, 0, 0);
        tick(); chk_all("idle1", 0, 0, 0);

        // scenario 1: one-shot from 3
        load = 1'b1; valor_carga = 4'd3;
        tick(); chk_all("s1.load", 3, 0, 1);
        load = 1'b0;
        tick(); chk_all("s1.c2", 2, 0, 1);
        tick(); chk_all("s1.c1", 1, 0, 1);
        tick(); chk_all("s1.fin", 0, 1, 0);
        tick(); chk_all("s1.idle", 0, 0, 0);
        tick(); chk_all("s1.hold", 0, 0, 0);

        // scenario 2: periodic reload of 5
        recarga_auto = 1'b1;
        load = 1'b1; valor_carga = 4'd5;
        tick(); chk_all("s2.load", 5, 0, 1);
        load = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_all($sformatf("s2.e%0d", i), seq[i], seq[i] == 5, 1);
        end

        // periodic with reload 1: cero on every enabled edge
        load = 1'b1; valor_carga = 4'd1;
        tick(); chk_all("r1.load", 1, 0, 1);
        load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all($sformatf("r1.e%0d", i), 1, 1, 1);
        end
        recarga_auto = 1'b0;
        tick(); chk_all("r1.oneshot", 0, 1, 0);
        tick(); chk_all("r1.idle", 0, 0, 0);

        // scenario 3: pause for 3 cycles mid-count
        load = 1'b1; valor_carga = 4'd4;
        tick(); chk_all("s3.load", 4, 0, 1);
        load = 1'b0;
        tick(); chk_all("s3.c3", 3, 0, 1);
        tick(); chk_all("s3.c2", 2, 0, 1);
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all($sformatf("s3.hold%0d", i), 2, 0, 1);
        end
        enable = 1'b1;
        tick(); chk_all("s3.c1", 1, 0, 1);
        tick(); chk_all("s3.fin", 0, 1, 0);
        tick(); chk_all("s3.idle", 0, 0, 0);

        // scenario 4: load beats enable
        load = 1'b1; valor_carga = 4'd4;
        tick(); chk_all("s4.load", 4, 0, 1);
        load = 1'b0;
        tick(); chk_all("s4.c3", 3, 0, 1);
        tick(); chk_all("s4.c2", 2, 0, 1);
        load = 1'b1; valor_carga = 4'd9;
        tick(); chk_all("s4.reload", 9, 0, 1);
        load = 1'b0;
        tick(); chk_all("s4.c8", 8, 0, 1);

        // scenario 5: zero load mid-count
        load = 1'b1; valor_carga = 4'd0;
        tick(); chk_all("s5.fin", 0, 1, 0);
        load = 1'b0;
        tick(); chk_all("s5.idle", 0, 0, 0);
        tick(); chk_all("s5.hold", 0, 0, 0);

        // scenario 6: asynchronous reset mid-count
        load = 1'b1; valor_carga = 4'd7;
        tick(); chk_all("s6.load", 7, 0, 1);
        load = 1'b0;
        tick(); chk_all("s6.c6", 6, 0, 1);
        #2 rst = 1'b0;
        #1 chk_all("s6.rst", 0, 0, 0);
        #1 rst = 1'b1;
        tick(); chk_all("s6.idle0", 0, 0, 0);
        tick(); chk_all("s6.idle1", 0, 0, 0);
        load = 1'b1; valor_carga = 4'd2;
        tick(); chk_all("s6.load2", 2, 0, 1);
        load = 1'b0;
        tick(); chk_all("s6.c1", 1, 0, 1);
        tick(); chk_all("s6.fin", 0, 1, 0);
        tick(); chk_all("s6.end", 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/contador_abajo_carga.md
CONTADOR_ABAJO_CARGA -- requirements
Module: contador_abajo_carga

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the counter width in bits (legal range 2..16).
REQ-002 Port clk, input, 1 bit, SHALL be the single clock; all state SHALL update on the falling edge.
REQ-003 Port rst, input, 1 bit, SHALL be the reset: asynchronous, active-low.
REQ-004 Port enable, input, 1 bit, SHALL permit one decrement per falling edge while counting.
REQ-005 Port load, input, 1 bit, SHALL request loading valor_carga into the counter and the reload register.
REQ-006 Port valor_carga, input, WIDTH bits, SHALL be the start or reload value, sampled only when load=1.
REQ-007 Port recarga_auto, input, 1 bit: 1 SHALL select periodic mode and 0 SHALL select one-shot mode; it is sampled at the terminal edge.
REQ-008 Port cuenta, output, WIDTH bits, SHALL be the current count, driven from a register.
REQ-009 Port cero, output, 1 bit, SHALL be a registered one-cycle pulse on terminal count.
REQ-010 Port ocupado, output, 1 bit, SHALL be 1 exactly while the FSM is in CONTANDO.

Function
REQ-011 The FSM SHALL have three states: IDLE, CONTANDO and FIN.
REQ-012 load=1 in any state SHALL set cuenta and the reload register to valor_carga.
REQ-013 On load=1, the next state SHALL be CONTANDO if valor_carga!=0, else FIN.
REQ-014 load SHALL take priority over enable on the same edge, and no decrement SHALL occur on a load edge.
REQ-015 In CONTANDO with enable=0, cuenta and the state SHALL hold.
REQ-016 In CONTANDO with enable=1 and cuenta>1, cuenta SHALL decrement by 1, modulo 2^WIDTH arithmetic; underflow is unreachable.
REQ-017 At the terminal edge (CONTANDO, enable=1, cuenta==1, recarga_auto=0), cuenta SHALL become 0, the next state SHALL be FIN and cero SHALL be 1 in the following cycle.
REQ-018 At the terminal edge with recarga_auto=1, cuenta SHALL become the reload register value, the FSM SHALL stay in CONTANDO and cero SHALL pulse for one cycle.
REQ-019 FIN SHALL last exactly one cycle with cero=1, then go to IDLE unless load=1.
REQ-020 In IDLE, enable SHALL have no effect; cuenta SHALL hold its value with no wrap from 0 to 2^WIDTH-1.
REQ-021 cero SHALL be 0 in every cycle except the one following a terminal event or a zero load.
REQ-022 With a reload register value of 1 and recarga_auto=1, cero SHALL pulse on every enabled edge.
REQ-023 Terminal-count latency SHALL be exactly N enabled edges after a load of N.

Reset
REQ-024 rst=0 SHALL asynchronously force state=IDLE, cuenta=0, reload register=0, cero=0 and ocupado=0.
REQ-025 Reset asserted mid-count SHALL abort the count and emit no cero pulse.
REQ-026 After rst deasserts, the block SHALL remain in IDLE until the first load=1.

Structure
REQ-027 Package contador_pkg SHALL hold the estado_t enum (IDLE, CONTANDO, FIN) and the default WIDTH constant.
REQ-028 The block SHALL be one module with no sub-module: a state register, a next-state/next-count process and a registered output.

Verification
REQ-029 Scenario 1: load valor_carga=3 with enable held at 1 -> cuenta 3,2,1,0, cero=1 for exactly one cycle after cuenta reaches 0, ocupado falls, state IDLE.
REQ-030 Scenario 2: load 5 with recarga_auto=1 and enable held at 1 -> cuenta 5,4,3,2,1,5,4..., with cero pulsing every 5 edges.
REQ-031 Scenario 3: load 4, then enable=0 for 3 cycles mid-count -> cuenta holds at its current value, and cero arrives 3 cycles later than in the uninterrupted case.
REQ-032 Scenario 4: load=1 with valor_carga=9 and enable=1 on the same edge while cuenta=2 -> cuenta=9 and no decrement occurs.
REQ-033 Scenario 5: load 0 -> state FIN, cero=1 for one cycle, ocupado stays 0, cuenta=0.
REQ-034 Scenario 6: rst pulsed low between edges while cuenta=6 -> immediate cuenta=0, no cero pulse, and enable ignored until the next load.
